alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, clocked successor to the team's 8-bit combinational ALU. It keeps the A/B/Ci/S/O operand-and-result style, generalises operand width, and adds:
- registered results with a start/done handshake;
- a stored flag register (C, Z, N, V), so ADC/SBB can chain multi-word arithmetic;
- a multi-cycle shift-add unsigned multiplier.

It sits between the register file and writeback in the lab datapath.

## Interface
Parameters:
- W, 8, operand width in bits (≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- A  in  W  operand A
- B  in  W  operand B
- Ci  in  1  carry-in / borrow-in / shift-in bit
- S  in  4  opcode
- start  in  1  operation request, sampled on the edge
- busy  out  1  high while a MUL is in progress
- done  out  1  one-cycle pulse: O/H/flags updated on this edge
- O  out  W+1  result; O[W] is carry/borrow/shift-out
- H  out  W  high half of last MUL product
- C, Z, N, V  out  1 each  carry/borrow, zero, negative, signed-overflow flags

## Operation
Opcodes (R = O[W-1:0]):
- 0 ADD: O = A+B+Ci.
- 1 SUB: O = ({0,A} − {0,B} − Ci) mod 2^(W+1); O[W] = borrow.
- 2 ADC: as ADD, carry-in = stored C.
- 3 SBB: as SUB, borrow-in = stored C.
- 4 AND, 5 OR, 6 XOR: O[W] = 0.
- 7 NOT: O = {0, ~A}.
- 8 SHL: O = {A, Ci}.
- 9 SHR: O = {A[0], Ci, A[W-1:1]}.
- 10 INC: A+1.
- 11 DEC: A−1, O[W] = borrow.
- 12 CMP: flags as SUB with Ci=0; O unchanged.
- 13 MUL: P = A·B unsigned, 2W bits; O = {0, P[W-1:0]}, H = P[2W-1:W].
- 14, 15 reserved: O, H and flags unchanged; done still pulses.

Flags:
- Arithmetic (0–3, 10–12): Z = (R==0), N = R[W-1], C = O[W]. V = operands of equal effective sign (B inverted for subtract) and result sign differs from A. INC/DEC use effective operand 1.
- Logic/NOT (4–7): C = 0, V = 0; Z, N from R.
- Shifts (8–9): C = O[W], V = 0; Z, N from R.
- MUL: Z = (P==0), N = P[2W-1], C = V = (H≠0).
- H changes only on MUL.

MUL FSM:
- IDLE: start with S=13 latches A, B, clears the partial product and iteration counter, and moves to RUN with busy=1.
- RUN: one shift-add step per cycle for W cycles. The last step writes O, H and flags, pulses done, and returns to IDLE.

## Timing
- Reset: O=0, H=0, C=Z=N=V=0, busy=0, done=0, FSM=IDLE.
- Single-cycle ops: start sampled high at edge t with busy=0 → O, flags and done=1 valid after edge t. done is low after t+1 unless a new start occurs. One op per cycle back-to-back is allowed, and ADC/SBB see the C written by the previous edge.
- MUL: start at edge t → busy=1 after edges t … t+W−1. At edge t+W: results written, busy=0, done=1. Latency is W+1 edges from start to results.
- A, B, Ci and S changes while busy=1 are ignored. start while busy=1 is dropped, with no queueing. The next start is accepted on the edge where done=1.
- rst mid-MUL: aborts immediately, no done pulse, all outputs take reset values.
- rst and start on the same edge: rst wins and start is dropped.

## Test plan (W=8)
- ADD A=0x8C B=0x13 Ci=1 → O=9'h0A0, C=0 Z=0 N=1 V=0, done one cycle after start.
- SUB A=0x13 B=0x8C Ci=0 → O=9'h187, C=1 N=1 V=1. Then CMP A=0x05 B=0x05 → Z=1 C=0, O still 9'h187.
- Chain: ADD A=0xFF B=0x01 Ci=0 → O=9'h100 C=1 Z=1. Next cycle ADC A=0 B=0 Ci=0 → O=9'h001 C=0.
- SHL A=0x8C Ci=1 → O=9'h119 C=1. SHR A=0x8C Ci=1 → O=9'h0C6 C=0 N=1.
- MUL A=0xFF B=0xFF → busy for 8 cycles, results on the 8th edge after start: O=9'h001 H=0xFE C=V=1 N=1. A start pulsed mid-run is ignored; A/B changed mid-run do not alter the result.
- MUL A=3 B=5, rst asserted on the 3rd busy cycle → busy=0, O=0, H=0, flags 0, no done pulse. Opcode 14 → O, flags unchanged, done=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with registered results, a start/done handshake,
// stored C/Z/N/V flags for multi-word ADC/SBB chains, and a W-cycle
// shift-add unsigned multiplier.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Ci,
  input  logic [3:0]   S,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [W:0]   O,
  output logic [W-1:0] H,
  output logic         C,
  output logic         Z,
  output logic         N,
  output logic         V
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_ADC = 4'd2,  OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_INC = 4'd10, OP_DEC = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12, OP_MUL = 4'd13;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [W-1:0]  a_reg, a_next;
  logic [W-1:0]  hi_reg, hi_next;
  logic [W-1:0]  lo_reg, lo_next;
  logic [W:0]    o_reg, o_next;
  logic [W-1:0]  h_reg, h_next;
  logic          c_reg, c_next, z_reg, z_next, n_reg, n_next, v_reg, v_next;
  logic          done_reg, done_next;

  // Shared adder/subtractor operands
  logic [W-1:0]  arith_b;
  logic          arith_cin;
  logic          arith_sub;
  logic [W:0]    arith_res;
  logic          arith_v;

  // Multiplier step datapath
  logic [W:0]    step_sum;
  logic [W-1:0]  step_hi;
  logic [W-1:0]  step_lo;

  // Single-cycle result staging
  logic [W:0]    res;
  logic          wr_o, wr_flags;
  logic          res_c, res_v;

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign O    = o_reg;
  assign H    = h_reg;
  assign C    = c_reg;
  assign Z    = z_reg;
  assign N    = n_reg;
  assign V    = v_reg;

  // Select effective second operand, carry/borrow-in and direction for arithmetic ops
  always_comb begin
    arith_b   = B;
    arith_cin = Ci;
    arith_sub = 1'b0;
    case (S)
      OP_SUB: arith_sub = 1'b1;
      OP_ADC: arith_cin = c_reg;
      OP_SBB: begin arith_sub = 1'b1; arith_cin = c_reg; end
      OP_INC: begin arith_b = W'(1); arith_cin = 1'b0; end
      OP_DEC: begin arith_b = W'(1); arith_cin = 1'b0; arith_sub = 1'b1; end
      OP_CMP: begin arith_cin = 1'b0; arith_sub = 1'b1; end
      default: ;
    endcase
    if (arith_sub)
      arith_res = {1'b0, A} - {1'b0, arith_b} - {{W{1'b0}}, arith_cin};
    else
      arith_res = {1'b0, A} + {1'b0, arith_b} + {{W{1'b0}}, arith_cin};
    // Overflow: operands agree in sign (B inverted for subtract) but result sign differs from A
    arith_v = (A[W-1] == (arith_b[W-1] ^ arith_sub)) && (arith_res[W-1] != A[W-1]);
  end

  // One shift-add multiply step: add A to the high half if the current multiplier bit is set, then shift right
  always_comb begin
    step_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : {(W+1){1'b0}});
    step_hi  = step_sum[W:1];
    step_lo  = {step_sum[0], lo_reg[W-1:1]};
  end

  // Next-state and result logic for the handshake and MUL FSM
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    o_next     = o_reg;
    h_next     = h_reg;
    c_next     = c_reg;
    z_next     = z_reg;
    n_next     = n_reg;
    v_next     = v_reg;
    done_next  = 1'b0;
    res        = arith_res;
    wr_o       = 1'b0;
    wr_flags   = 1'b0;
    res_c      = arith_res[W];
    res_v      = arith_v;

    case (state_reg)
      IDLE: begin
        if (start) begin
          done_next = 1'b1;
          case (S)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_INC, OP_DEC: begin
              wr_o = 1'b1; wr_flags = 1'b1;
            end
            OP_CMP: wr_flags = 1'b1;
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
              case (S)
                OP_AND:  res = {1'b0, A & B};
                OP_OR:   res = {1'b0, A | B};
                OP_XOR:  res = {1'b0, A ^ B};
                default: res = {1'b0, ~A};
              endcase
              res_c = 1'b0; res_v = 1'b0;
              wr_o = 1'b1; wr_flags = 1'b1;
            end
            OP_SHL, OP_SHR: begin
              res   = (S == OP_SHL) ? {A, Ci} : {A[0], Ci, A[W-1:1]};
              res_c = res[W];
              res_v = 1'b0;
              wr_o = 1'b1; wr_flags = 1'b1;
            end
            OP_MUL: begin
              done_next  = 1'b0;
              a_next     = A;
              hi_next    = '0;
              lo_next    = B;
              cnt_next   = '0;
              state_next = RUN;
            end
            default: ;  // reserved opcodes only acknowledge
          endcase
          if (wr_o) o_next = res;
          if (wr_flags) begin
            c_next = res_c;
            z_next = (res[W-1:0] == '0);
            n_next = res[W-1];
            v_next = res_v;
          end
        end
      end
      RUN: begin
        hi_next  = step_hi;
        lo_next  = step_lo;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST_STEP) begin
          o_next     = {1'b0, step_lo};
          h_next     = step_hi;
          z_next     = ({step_hi, step_lo} == '0);
          n_next     = step_hi[W-1];
          c_next     = (step_hi != '0);
          v_next     = (step_hi != '0);
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and result registers; reset aborts any multiply in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      o_reg     <= '0;
      h_reg     <= '0;
      c_reg     <= 1'b0;
      z_reg     <= 1'b0;
      n_reg     <= 1'b0;
      v_reg     <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      o_reg     <= o_next;
      h_reg     <= h_next;
      c_reg     <= c_next;
      z_reg     <= z_next;
      n_reg     <= n_next;
      v_reg     <= v_next;
      done_reg  <= done_next;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (W=8). Expected results are queued
// when an operation is issued and compared when the DUT pulses done.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B;
  logic         Ci;
  logic [3:0]   S;
  logic         start;
  logic         busy, done;
  logic [W:0]   O;
  logic [W-1:0] H;
  logic         C, Z, N, V;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [8:0] o;
    logic [7:0] h;
    logic [3:0] f;  // {C,Z,N,V}
  } exp_t;

  exp_t sb_q[$];
  logic [7:0] tb_h;

  alu_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Ci(Ci), .S(S), .start(start),
    .busy(busy), .done(done), .O(O), .H(H), .C(C), .Z(Z), .N(N), .V(V)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request at the next falling edge and queue its expected result
  task automatic issue(input string tag, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [8:0] eo, input logic [7:0] eh, input logic [3:0] ef);
    exp_t e;
    @(negedge clk);
    S = s; A = a; B = b; Ci = ci; start = 1'b1;
    e.tag = tag; e.o = eo; e.h = eh; e.f = ef;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference model for the randomised section
  function automatic exp_t model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b, input logic ci);
    exp_t e;
    int full;
    logic [15:0] p;
    logic [7:0] r;
    e.tag = "rand"; e.h = tb_h;
    case (s)
      4'd0: begin
        full = int'(a) + int'(b) + int'(ci);
        e.o = full[8:0]; r = e.o[7:0];
        e.f = {e.o[8], r == 8'h00, r[7], (a[7] == b[7]) && (r[7] != a[7])};
      end
      4'd1: begin
        full = int'(a) - int'(b) - int'(ci);
        e.o = full[8:0]; r = e.o[7:0];
        e.f = {full < 0, r == 8'h00, r[7], (a[7] != b[7]) && (r[7] != a[7])};
      end
      4'd6: begin
        r = a ^ b; e.o = {1'b0, r};
        e.f = {1'b0, r == 8'h00, r[7], 1'b0};
      end
      default: begin
        p = 16'(a) * 16'(b);
        e.o = {1'b0, p[7:0]}; e.h = p[15:8];
        e.f = {p[15:8] != 8'h00, p == 16'h0000, p[15], p[15:8] != 8'h00};
      end
    endcase
    return e;
  endfunction

  // Scoreboard: every done pulse is matched against the oldest queued expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("[TB] %s O=%h H=%h CZNV=%b", e.tag, O, H, {C, Z, N, V});
        check_val({e.tag, "_O"}, 32'(O), 32'(e.o));
        check_val({e.tag, "_H"}, 32'(H), 32'(e.h));
        check_val({e.tag, "_CZNV"}, 32'({C, Z, N, V}), 32'(e.f));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [3:0] ops [4];
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd6; ops[3] = 4'd13;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Ci = 1'b0; S = '0;
    repeat (3) @(negedge clk);
    check_val("rst_O", 32'(O), 32'd0);
    check_val("rst_H", 32'(H), 32'd0);
    check_val("rst_flags", 32'({C, Z, N, V}), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Single-cycle ops; done visible one edge after start, low on the next
    issue("add", 4'd0, 8'h8C, 8'h13, 1'b1, 9'h0A0, 8'h00, 4'b0010);
    idle();
    @(negedge clk);
    check_val("add_done_low", 32'(done), 32'd0);
    issue("sub", 4'd1, 8'h13, 8'h8C, 1'b0, 9'h187, 8'h00, 4'b1011);
    issue("cmp", 4'd12, 8'h05, 8'h05, 1'b1, 9'h187, 8'h00, 4'b0100);
    issue("add_ff", 4'd0, 8'hFF, 8'h01, 1'b0, 9'h100, 8'h00, 4'b1100);
    issue("adc", 4'd2, 8'h00, 8'h00, 1'b0, 9'h001, 8'h00, 4'b0000);
    issue("sub_b", 4'd1, 8'h00, 8'h01, 1'b0, 9'h1FF, 8'h00, 4'b1010);
    issue("sbb", 4'd3, 8'h00, 8'h00, 1'b0, 9'h1FF, 8'h00, 4'b1010);
    issue("shl", 4'd8, 8'h8C, 8'h00, 1'b1, 9'h119, 8'h00, 4'b1000);
    issue("shr", 4'd9, 8'h8C, 8'h00, 1'b1, 9'h0C6, 8'h00, 4'b0010);
    issue("inc", 4'd10, 8'hFF, 8'h00, 1'b0, 9'h100, 8'h00, 4'b1100);
    issue("dec", 4'd11, 8'h80, 8'h00, 1'b0, 9'h07F, 8'h00, 4'b0001);
    issue("and", 4'd4, 8'hF0, 8'h3C, 1'b1, 9'h030, 8'h00, 4'b0000);
    issue("or", 4'd5, 8'h80, 8'h01, 1'b1, 9'h081, 8'h00, 4'b0010);
    issue("not", 4'd7, 8'h0F, 8'h00, 1'b1, 9'h0F0, 8'h00, 4'b0010);
    idle();

    // MUL 0xFF*0xFF with a dropped start and operand changes mid-run
    issue("mul_ff", 4'd13, 8'hFF, 8'hFF, 1'b0, 9'h001, 8'hFE, 4'b1011);
    idle();
    check_val("mul_busy_1", 32'(busy), 32'd1);
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      check_val("mul_busy", 32'(busy), 32'd1);
      if (k == 4) begin S = 4'd0; A = 8'h01; B = 8'h02; start = 1'b1; end
      if (k == 5) start = 1'b0;
    end
    @(negedge clk);
    check_val("mul_busy_end", 32'(busy), 32'd0);
    check_val("mul_done", 32'(done), 32'd1);
    tb_h = 8'hFE;

    // Randomised ADD/SUB/XOR/MUL against the reference model
    for (int i = 0; i < 12; i++) begin
      logic [3:0] s;
      logic [7:0] a, b;
      logic ci;
      s = ops[$urandom_range(0, 3)];
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      e = model(s, a, b, ci);
      issue(e.tag, s, a, b, ci, e.o, e.h, e.f);
      tb_h = e.h;
      idle();
      if (s == 4'd13) repeat (W) @(negedge clk);
    end

    // Reset in the middle of a multiply: no done, everything back to reset values
    issue("mul_abort", 4'd13, 8'h03, 8'h05, 1'b0, 9'h00F, 8'h00, 4'b0000);
    idle();
    @(negedge clk);
    rst = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_O", 32'(O), 32'd0);
    check_val("abort_H", 32'(H), 32'd0);
    check_val("abort_flags", 32'({C, Z, N, V}), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    repeat (W + 2) @(negedge clk);

    // Reserved opcode acknowledges without touching O, H or flags
    issue("add_pre", 4'd0, 8'h8C, 8'h13, 1'b1, 9'h0A0, 8'h00, 4'b0010);
    issue("rsvd14", 4'd14, 8'h55, 8'hAA, 1'b1, 9'h0A0, 8'h00, 4'b0010);
    idle();
    repeat (2) @(negedge clk);

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
